// File: rtl/mul_serial_pkg.sv
// Shared types for the serial multiplier lane sequencer.
// State encoding and product-width helper.
package mul_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_border.sv
// Bit-index stepper for one serial multiplier lane.
// Emits the sign-extended partial product for the current index.
module mul_border
  import mul_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           i_data0,
  input  logic [WIDTH-1:0]           i_data1,
  input  logic [DEPTH-1:0]           i_idx,
  output logic [prod_w(WIDTH)-1:0]   o_data,
  output logic [DEPTH-1:0]           o_idx
);

  logic [DEPTH-1:0] idx_q;
  logic [DEPTH-1:0] idx_d;

  // next index: load on clr, advance on en
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = i_idx;
    end else if (en) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // partial product: multiplicand gated by the selected multiplier bit
  always_comb begin
    o_data = '0;
    if (i_data0[idx_q]) begin
      o_data = {{WIDTH{i_data1[WIDTH-1]}}, i_data1};
    end
  end

  assign o_idx = idx_q;

endmodule

// File: rtl/mul_serial_ctrl.sv
// Sequencer for one bit-serial signed multiplier lane.
// Optional early termination: MUL_SERIAL_CTRL_EARLY_TERM_EN.
module mul_serial_ctrl
  import mul_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_prod,
  output logic                   busy
);

  localparam int PW = prod_w(WIDTH);
  localparam logic [DEPTH-1:0] LAST = DEPTH'(WIDTH - 1);

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        a_q, a_d;
  logic [WIDTH-1:0]        b_q, b_d;
  logic signed [PW-1:0]    acc_q, acc_d;
  logic [DEPTH-1:0]        cnt_q, cnt_d;
  logic                    en;
  logic                    clr;
  logic [PW-1:0]           pp;
  logic [DEPTH-1:0]        idx;
  logic signed [PW-1:0]    pp_sh;
  logic                    last;
  logic                    finish;

  mul_border #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_border (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .i_data0 (a_q),
    .i_data1 (b_q),
    .i_idx   ('0),
    .o_data  (pp),
    .o_idx   (idx)
  );

  assign pp_sh = signed'(pp) << cnt_q;
  assign last  = (cnt_q == LAST);

`ifdef MUL_SERIAL_CTRL_EARLY_TERM_EN
  logic [WIDTH-1:0] a_hi;
  assign a_hi   = (a_q >> cnt_q) >> 1;
  assign finish = last || (a_hi == '0);
`else
  assign finish = last;
`endif

  // next-state, datapath update and border controls
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    en      = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        en    = 1'b1;
        acc_d = last ? acc_q - pp_sh : acc_q + pp_sh;
        if (finish) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CLR) || (state_q == RUN);
  assign out_prod  = (state_q == DONE) ? acc_q : '0;

`ifndef SYNTHESIS
  a_idx_track: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> (idx == cnt_q)
  );
`endif

endmodule
